// File: rtl/led_fader_pkg.sv
// rtl/led_fader_pkg.sv - shared defaults, target encodings and level-maximum helper for led_fader
package led_fader_pkg;

  localparam int DEF_NB   = 4;
  localparam int DEF_PW   = 8;
  localparam int DEF_NS   = 16;
  localparam int DEF_STEP = 8;

  localparam logic TGT_ON  = 1'b1;
  localparam logic TGT_OFF = 1'b0;

  function automatic int lvl_max(input int pw);
    return (1 << pw) - 1;
  endfunction

endpackage

// File: rtl/led_fader_fade_channel.sv
// rtl/led_fader_fade_channel.sv - one LED: saturating brightness fade, PWM compare, at-target flag
module led_fader_fade_channel
  import led_fader_pkg::*;
#(
  parameter int PW   = DEF_PW,
  parameter int STEP = DEF_STEP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          tgt_on,
  input  logic [PW-1:0] pwm_cnt,
  output logic          led,
  output logic          at_tgt
);

  localparam int MAX = lvl_max(PW);
  localparam logic [PW:0] MAX_W  = MAX[PW:0];
  localparam logic [PW:0] STEP_W = STEP[PW:0];

  logic [PW-1:0] lvl_q, lvl_d;
  logic [PW-1:0] tgt;
  logic [PW:0]   up, dn;
  logic          led_q, led_d;

  always_comb begin
    tgt   = (tgt_on == TGT_ON) ? MAX_W[PW-1:0] : '0;
    // one extra bit so overshoot above MAX or borrow below 0 is visible
    up    = {1'b0, lvl_q} + STEP_W;
    dn    = {1'b0, lvl_q} - STEP_W;
    lvl_d = lvl_q;
    if (tick) begin
      if (lvl_q < tgt) begin
        lvl_d = (up > MAX_W) ? MAX_W[PW-1:0] : up[PW-1:0];
      end else if (lvl_q > tgt) begin
        lvl_d = dn[PW] ? '0 : dn[PW-1:0];
      end
    end
    led_d = (pwm_cnt < lvl_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= '0;
      led_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      led_q <= led_d;
    end
  end

  assign led    = led_q;
  assign at_tgt = (lvl_d == tgt);

endmodule

// File: rtl/led_fader.sv
// rtl/led_fader.sv - PWM LED fader top: input sync, shared PWM/tick counters, busy
// Optional pattern-change counter on chg_cnt when LED_FADER_CHG_CNT_EN is defined.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int NB   = DEF_NB,
  parameter int PW   = DEF_PW,
  parameter int NS   = DEF_NS,
  parameter int STEP = DEF_STEP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NB-1:0] din,
  output logic [NB-1:0] led,
  output logic          busy
`ifdef LED_FADER_CHG_CNT_EN
  ,
  output logic [7:0]    chg_cnt
`endif
);

  logic [NB-1:0] din_q, din_d;
  logic [PW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NS-1:0] tick_cnt_q, tick_cnt_d;
  logic          busy_q, busy_d;
  logic          tick;
  logic [NB-1:0] at_tgt;

  always_comb begin
    din_d      = din;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    tick_cnt_d = tick_cnt_q + 1'b1;
    tick       = &tick_cnt_q;
    busy_d     = ~(&at_tgt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q      <= '0;
      pwm_cnt_q  <= '0;
      tick_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      din_q      <= din_d;
      pwm_cnt_q  <= pwm_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      busy_q     <= busy_d;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_ch
    led_fader_fade_channel #(
      .PW   (PW),
      .STEP (STEP)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .tgt_on  (din_q[i]),
      .pwm_cnt (pwm_cnt_q),
      .led     (led[i]),
      .at_tgt  (at_tgt[i])
    );
  end

  assign busy = busy_q;

`ifdef LED_FADER_CHG_CNT_EN
  logic [7:0] chg_cnt_q, chg_cnt_d;

  always_comb begin
    chg_cnt_d = chg_cnt_q;
    if (din != din_q) begin
      chg_cnt_d = chg_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chg_cnt_q <= '0;
    end else begin
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign chg_cnt = chg_cnt_q;
`endif

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - randomized and directed checks of led_fader against an arithmetic model
module tb_led_fader;

  localparam int NB = 4, PW = 4, NS = 2, STEP = 4;
  localparam int MAX = 15;
  localparam int TICK_PERIOD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] din = '0;
  logic [NB-1:0] led;
  logic          busy;
`ifdef LED_FADER_CHG_CNT_EN
  logic [7:0]    chg_cnt;
`endif

  led_fader #(.NB(NB), .PW(PW), .NS(NS), .STEP(STEP)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .led  (led),
    .busy (busy)
`ifdef LED_FADER_CHG_CNT_EN
    ,
    .chg_cnt (chg_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state: cycles since reset drive the PWM phase and tick timing
  int       m_cyc;
  int       m_lvl [NB];
  bit [3:0] m_din_q;
  bit [3:0] m_led;
  bit       m_busy;
  int       m_chg;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clock(input bit r, input bit [3:0] d);
    bit tick;
    int pwm, tgt;
    if (r) begin
      m_cyc = 0; m_din_q = 0; m_led = 0; m_busy = 0; m_chg = 0;
      for (int i = 0; i < NB; i++) m_lvl[i] = 0;
      return;
    end
    tick   = ((m_cyc % TICK_PERIOD) == TICK_PERIOD - 1);
    pwm    = m_cyc % (MAX + 1);
    m_busy = 0;
    for (int i = 0; i < NB; i++) begin
      m_led[i] = (pwm < m_lvl[i]);
      tgt = m_din_q[i] ? MAX : 0;
      if (tick) begin
        if (m_lvl[i] < tgt)      m_lvl[i] = (m_lvl[i] + STEP > MAX) ? MAX : m_lvl[i] + STEP;
        else if (m_lvl[i] > tgt) m_lvl[i] = (m_lvl[i] - STEP < 0) ? 0 : m_lvl[i] - STEP;
      end
      if (m_lvl[i] != tgt) m_busy = 1;
    end
    if (d != m_din_q) m_chg = (m_chg + 1) % 256;
    m_din_q = d;
    m_cyc++;
  endtask

  task automatic step(input bit r, input bit [3:0] d);
    rst = r;
    din = d;
    @(posedge clk);
    model_clock(r, d);
    #1;
    check("led", int'(led), int'(m_led));
    check("busy", int'(busy), int'(m_busy));
`ifdef LED_FADER_CHG_CNT_EN
    check("chg_cnt", int'(chg_cnt), m_chg);
`endif
  endtask

  task automatic duty_count(input bit [3:0] d, output int hi0, output int hi_rest);
    hi0 = 0; hi_rest = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, d);
      hi0 += int'(led[0]);
      hi_rest += int'(led[3:1] != 3'b000);
    end
  endtask

  initial begin
    int h0, hr;
    bit [3:0] rd;
    model_clock(1'b1, 4'h0);

    // reset held with all channels requested on
    for (int k = 0; k < 3; k++) step(1'b1, 4'hF);
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    step(1'b0, 4'hF);
    step(1'b0, 4'hF);
    check("release_busy", int'(busy), 1);

    // single channel fades up to full brightness
    step(1'b1, 4'h0);
    for (int k = 0; k < 24; k++) step(1'b0, 4'b0001);
    check("up_done_busy", int'(busy), 0);
    duty_count(4'b0001, h0, hr);
    check("full_duty", h0, 15);
    check("others_dark", hr, 0);

    // fade back down to off
    for (int k = 0; k < 24; k++) step(1'b0, 4'b0000);
    check("down_done_busy", int'(busy), 0);
    duty_count(4'b0000, h0, hr);
    check("off_duty", h0, 0);

    // reversal after two up-ticks (level 8): two down-ticks reach 0
    step(1'b1, 4'h0);
    for (int k = 0; k < 8; k++) step(1'b0, 4'b0001);
    for (int k = 0; k < 8; k++) step(1'b0, 4'b0000);
    check("reverse_busy", int'(busy), 0);
    duty_count(4'b0000, h0, hr);
    check("reverse_duty", h0, 0);

    // reset in the middle of a fade
    step(1'b1, 4'h0);
    for (int k = 0; k < 10; k++) step(1'b0, 4'b0001);
    check("midfade_busy", int'(busy), 1);
    step(1'b1, 4'b0001);
    check("midrst_led", int'(led), 0);
    check("midrst_busy", int'(busy), 0);
    step(1'b0, 4'b0001);
    check("midrst_led_after", int'(led), 0);

`ifdef LED_FADER_CHG_CNT_EN
    step(1'b1, 4'h0);
    for (int k = 0; k < 300; k++) step(1'b0, (k % 2 == 0) ? 4'h1 : 4'h0);
    check("chg_cnt_wrap", int'(chg_cnt), 44);
`endif

    // random patterns with occasional resets
    step(1'b1, 4'h0);
    rd = 4'h0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7, 0) == 0) rd = 4'($urandom_range(15, 0));
      step($urandom_range(199, 0) == 0, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
